// File: rtl/heap_memory.sv
// Small heap of fixed-capacity arrays with allocate/free, random access and
// stack-style push/pop, driven by a one-request-at-a-time valid/ready handshake.
module heap_memory #(
    parameter int ARRAYS     = 8,
    parameter int ARRAY_SIZE = 16,
    parameter int DATA_BITS  = 12
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [7:0]                    req_action,
    input  logic [$clog2(ARRAYS)-1:0]     req_array,
    input  logic [$clog2(ARRAY_SIZE)-1:0] req_index,
    input  logic [DATA_BITS-1:0]          req_data,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [DATA_BITS-1:0]          resp_data,
    output logic                          resp_error,
    output logic [$clog2(ARRAYS):0]       allocated_count
);

    localparam int AW = $clog2(ARRAYS);
    localparam int IW = $clog2(ARRAY_SIZE);
    localparam int SW = IW + 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_e;

    typedef enum logic [7:0] {
        ACT_CLEAR = 8'd1,
        ACT_ALLOC = 8'd2,
        ACT_FREE  = 8'd3,
        ACT_WRITE = 8'd4,
        ACT_READ  = 8'd5,
        ACT_SIZE  = 8'd6,
        ACT_PUSH  = 8'd7,
        ACT_POP   = 8'd8
    } action_e;

    state_e                       state_q, state_d;
    logic [7:0]                   reqAction_q, reqAction_d;
    logic [AW-1:0]                reqArray_q, reqArray_d;
    logic [IW-1:0]                reqIndex_q, reqIndex_d;
    logic [DATA_BITS-1:0]         reqData_q, reqData_d;
    logic [DATA_BITS-1:0]         respData_q, respData_d;
    logic                         respError_q, respError_d;
    logic [ARRAYS-1:0]            alloc_q, alloc_d;
    logic [ARRAYS-1:0][SW-1:0]    size_q, size_d;

    // Element storage is deliberately not reset; contents of a freshly
    // allocated array are undefined until written.
    logic [DATA_BITS-1:0]         mem_q [ARRAYS][ARRAY_SIZE];

    logic                         memWe;
    logic [IW-1:0]                memIdx;
    logic                         freeFound;
    logic [AW-1:0]                freeIdx;
    logic [SW-1:0]                curSize;
    logic                         curAlloc;
    logic [SW-1:0]                idxExt;
    logic [IW-1:0]                popIdx;
    logic [DATA_BITS-1:0]         readData;
    logic [DATA_BITS-1:0]         popData;
    logic [CW-1:0]                countOnes;

    assign curSize  = size_q[reqArray_q];
    assign curAlloc = alloc_q[reqArray_q];
    assign idxExt   = SW'(reqIndex_q);
    assign popIdx   = IW'(curSize - SW'(1));
    assign readData = mem_q[reqArray_q][reqIndex_q];
    assign popData  = mem_q[reqArray_q][popIdx];

    // Scan downwards so the last hit is the lowest-numbered free array.
    always_comb begin
        freeFound = 1'b0;
        freeIdx   = '0;
        for (int i = ARRAYS - 1; i >= 0; i--) begin
            if (!alloc_q[i]) begin
                freeFound = 1'b1;
                freeIdx   = AW'(i);
            end
        end
    end

    always_comb begin
        countOnes = '0;
        for (int i = 0; i < ARRAYS; i++) begin
            countOnes = countOnes + CW'(alloc_q[i]);
        end
    end

    always_comb begin
        state_d     = state_q;
        reqAction_d = reqAction_q;
        reqArray_d  = reqArray_q;
        reqIndex_d  = reqIndex_q;
        reqData_d   = reqData_q;
        respData_d  = respData_q;
        respError_d = respError_q;
        alloc_d     = alloc_q;
        size_d      = size_q;
        memWe       = 1'b0;
        memIdx      = reqIndex_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    reqAction_d = req_action;
                    reqArray_d  = req_array;
                    reqIndex_d  = req_index;
                    reqData_d   = req_data;
                    state_d     = EXEC;
                end
            end

            EXEC: begin
                state_d     = RESP;
                respData_d  = '0;
                respError_d = 1'b0;
                case (reqAction_q)
                    ACT_CLEAR: begin
                        alloc_d = '0;
                        size_d  = '0;
                    end
                    ACT_ALLOC: begin
                        if (freeFound) begin
                            alloc_d[freeIdx] = 1'b1;
                            size_d[freeIdx]  = '0;
                            respData_d       = DATA_BITS'(freeIdx);
                        end else begin
                            respError_d = 1'b1;
                        end
                    end
                    ACT_FREE: begin
                        if (curAlloc) begin
                            alloc_d[reqArray_q] = 1'b0;
                            size_d[reqArray_q]  = '0;
                        end else begin
                            respError_d = 1'b1;
                        end
                    end
                    ACT_WRITE: begin
                        if (!curAlloc || idxExt >= SW'(ARRAY_SIZE)) begin
                            respError_d = 1'b1;
                        end else begin
                            memWe  = 1'b1;
                            memIdx = reqIndex_q;
                            if (idxExt >= curSize) begin
                                size_d[reqArray_q] = idxExt + SW'(1);
                            end
                        end
                    end
                    ACT_READ: begin
                        if (!curAlloc || idxExt >= curSize) begin
                            respError_d = 1'b1;
                        end else begin
                            respData_d = readData;
                        end
                    end
                    ACT_SIZE: begin
                        if (curAlloc) begin
                            respData_d = DATA_BITS'(curSize);
                        end else begin
                            respError_d = 1'b1;
                        end
                    end
                    ACT_PUSH: begin
                        if (!curAlloc || curSize == SW'(ARRAY_SIZE)) begin
                            respError_d = 1'b1;
                        end else begin
                            memWe              = 1'b1;
                            memIdx             = IW'(curSize);
                            size_d[reqArray_q] = curSize + SW'(1);
                        end
                    end
                    ACT_POP: begin
                        if (!curAlloc || curSize == '0) begin
                            respError_d = 1'b1;
                        end else begin
                            size_d[reqArray_q] = curSize - SW'(1);
                            respData_d         = popData;
                        end
                    end
                    default: begin
                        respError_d = 1'b1;
                    end
                endcase
            end

            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            reqAction_q <= '0;
            reqArray_q  <= '0;
            reqIndex_q  <= '0;
            reqData_q   <= '0;
            respData_q  <= '0;
            respError_q <= 1'b0;
            alloc_q     <= '0;
            size_q      <= '0;
        end else begin
            state_q     <= state_d;
            reqAction_q <= reqAction_d;
            reqArray_q  <= reqArray_d;
            reqIndex_q  <= reqIndex_d;
            reqData_q   <= reqData_d;
            respData_q  <= respData_d;
            respError_q <= respError_d;
            alloc_q     <= alloc_d;
            size_q      <= size_d;
        end
    end

    always_ff @(posedge clock) begin
        if (memWe) begin
            mem_q[reqArray_q][memIdx] <= reqData_q;
        end
    end

    assign req_ready       = (state_q == IDLE);
    assign resp_valid      = (state_q == RESP);
    assign resp_data       = respData_q;
    assign resp_error      = respError_q;
    assign allocated_count = countOnes;

endmodule

// File: doc/heap_memory.md
HEAP_MEMORY -- requirements
Module: heap_memory

Interface
REQ-001 SHALL provide parameter ARRAYS, default 8, meaning number of arrays in the heap.
REQ-002 SHALL provide parameter ARRAY_SIZE, default 16, meaning maximum elements per array.
REQ-003 SHALL provide parameter DATA_BITS, default 12, meaning element width.
REQ-004 SHALL provide port clock, input, 1, the single clock; all state changes on posedge clock.
REQ-005 SHALL provide port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL provide port req_valid, input, 1, request present.
REQ-007 SHALL provide port req_ready, output, 1, high when a request can be accepted.
REQ-008 SHALL provide port req_action, input, 8, operation code (REQ-014).
REQ-009 SHALL provide ports req_array, input, clog2(ARRAYS), target array; req_index, input, clog2(ARRAY_SIZE), element index; req_data, input, DATA_BITS, write/push data.
REQ-010 SHALL provide port resp_valid, output, 1, response present.
REQ-011 SHALL provide port resp_ready, input, 1, response consumed.
REQ-012 SHALL provide ports resp_data, output, DATA_BITS, result; resp_error, output, 1, operation rejected.
REQ-013 SHALL provide port allocated_count, output, clog2(ARRAYS)+1, number of arrays currently allocated.

Function
REQ-014 SHALL decode req_action: 1 clear, 2 allocate, 3 free, 4 write, 5 read, 6 size, 7 push, 8 pop; any other code: no state change, resp_error=1, resp_data=0.
REQ-015 SHALL implement states IDLE, EXEC, RESP; req_ready=1 only in IDLE.
REQ-016 SHALL accept a request on a posedge with req_valid=1 in IDLE, register all req_* fields, go to EXEC.
REQ-017 SHALL in EXEC perform the operation and load resp_data/resp_error, go to RESP; resp_valid=1 exactly in RESP (first valid edge = acceptance edge + 2).
REQ-018 SHALL hold resp_valid, resp_data, resp_error stable in RESP until a posedge with resp_ready=1, then return to IDLE; resp_ready outside RESP is ignored.
REQ-019 SHALL for clear: free all arrays, zero all sizes, resp_data=0, resp_error=0.
REQ-020 SHALL for allocate: mark lowest-numbered free array allocated with size 0, resp_data=its index; if none free, resp_error=1, resp_data=0.
REQ-021 SHALL for free: deallocate req_array, set size 0; error if not allocated.
REQ-022 SHALL for write: store req_data at req_index, size=max(size, req_index+1); error if array unallocated or req_index>=ARRAY_SIZE.
REQ-023 SHALL for read: resp_data=element at req_index; error (resp_data=0) if unallocated or req_index>=size.
REQ-024 SHALL for size: resp_data=current size zero-extended; error if unallocated.
REQ-025 SHALL for push: store req_data at position size, increment size; error if unallocated or size==ARRAY_SIZE (full).
REQ-026 SHALL for pop: decrement size, resp_data=element at new size; error if unallocated or size==0 (empty).
REQ-027 SHALL leave all state unchanged on any errored operation; element contents of freed arrays are undefined when reallocated, size is 0.
REQ-028 SHALL update allocated_count in the same edge as the EXEC operation that changes it.

Reset
REQ-029 SHALL on reset=1, immediately and regardless of clock: state=IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_error=0, allocated_count=0, all arrays free, all sizes 0.
REQ-030 SHALL abort any in-flight request on reset (in EXEC or RESP) with no response delivered; element storage need not be cleared.

Verification
REQ-031 SHALL cover: reset, allocate x3 -> resp_data 0,1,2, resp_error=0, allocated_count=3, resp_valid two edges after acceptance.
REQ-032 SHALL cover: allocate array 0, write index 3 value 5, size -> 4; read index 3 -> 5; read index 4 -> resp_error=1, resp_data=0.
REQ-033 SHALL cover: push 16 values to one array -> all ok; 17th push -> resp_error=1; 16 pops return values in reverse order; 17th pop -> resp_error=1.
REQ-034 SHALL cover: allocate all 8, 9th allocate -> error; free 5 then allocate -> resp_data=5; free unallocated array -> error; action 0 and 9 -> error.
REQ-035 SHALL cover: resp_ready held low 10 cycles -> response stable, req_ready=0 throughout; req_valid during RESP not accepted.
REQ-036 SHALL cover: reset asserted mid-clock while in EXEC -> resp_valid stays 0, allocated_count=0 without a clock edge.
